// File: rtl/pulse_stretch_driver.sv
// pulse_stretch_driver: stretches one-cycle triggers into pulses with exact high time and minimum low gap.
// Define PULSE_QUEUE_EN to queue requests that arrive while busy instead of dropping them.
module pulse_stretch_driver #(
  parameter int HIGH_CYCLES = 1000,
  parameter int LOW_CYCLES  = 1000,
  parameter int CNT_WIDTH   = 20,
  parameter int QDEPTH_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                trig_in,
  output logic                pulse_out,
  output logic                busy,
  output logic [QDEPTH_W-1:0] pending,
  output logic                drop_pulse
);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  localparam logic [CNT_WIDTH-1:0] HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOW_LOAD  = CNT_WIDTH'(LOW_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [QDEPTH_W-1:0] pend_q, pend_d;
  logic pulse_q, pulse_d, busy_q, busy_d, drop_q, drop_d;
  logic tmr_zero, gap_end, go, req;
`ifdef PULSE_QUEUE_EN
  logic push, pop;
`endif
  always_comb begin
    tmr_zero = timer_q == '0;
    gap_end  = state_q == GAP && tmr_zero;
    go       = trig_in || pend_q != '0;
    req      = trig_in && state_q != IDLE;
    state_d  = state_q;
    timer_d  = tmr_zero ? timer_q : timer_q - 1'b1;
    unique case (state_q)
      IDLE: if (trig_in) begin state_d = HIGH; timer_d = HIGH_LOAD; end
      HIGH: if (tmr_zero) begin state_d = GAP; timer_d = LOW_LOAD; end
      GAP:  if (tmr_zero) begin state_d = go ? HIGH : IDLE; timer_d = go ? HIGH_LOAD : '0; end
      default: begin state_d = IDLE; timer_d = '0; end
    endcase
`ifdef PULSE_QUEUE_EN
    // a trigger at the last gap cycle with an empty queue starts the next pulse directly
    push   = req && !(gap_end && pend_q == '0);
    pop    = gap_end && pend_q != '0;
    drop_d = push && !pop && pend_q == '1;
    pend_d = (push && !pop && !drop_d) ? pend_q + 1'b1 : (pop && !push) ? pend_q - 1'b1 : pend_q;
`else
    drop_d = req && !gap_end;
    pend_d = '0;
`endif
    pulse_d = state_d == HIGH;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  assign pulse_out  = pulse_q;
  assign busy       = busy_q;
  assign pending    = pend_q;
  assign drop_pulse = drop_q;
endmodule

// File: tb/tb_pulse_stretch_driver.sv
// tb_pulse_stretch_driver: directed and random checks of pulse_stretch_driver against a pulse-window reference model.
`timescale 1ns/1ps
module tb_pulse_stretch_driver;
  localparam int H = 4, L = 3, QW = 2, PMAX = 3;
  logic clk = 1'b0, reset_n = 1'b0, trig_in = 1'b0;
  logic pulse_out, busy, drop_pulse;
  logic [QW-1:0] pending;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int m_start = -100, m_pend = 0;
  logic m_drop = 1'b0;
  logic obs_p [0:127];
  logic obs_b [0:127];
  logic obs_d [0:127];
  int   obs_q [0:127];

  pulse_stretch_driver #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .CNT_WIDTH(8), .QDEPTH_W(QW)) dut (
    .clk(clk), .reset_n(reset_n), .trig_in(trig_in), .pulse_out(pulse_out),
    .busy(busy), .pending(pending), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference: a pulse that starts at m_start owns cycles [m_start, m_start+H+L), high for the first H.
  task automatic model(input logic t);
    logic active, last;
    active = cyc >= m_start && cyc < m_start + H + L;
    last   = cyc == m_start + H + L - 1;
    m_drop = 1'b0;
    if (!active) begin
      if (t) m_start = cyc + 1;
    end else if (last && (m_pend > 0 || t)) begin
      m_start = cyc + 1;
      if (m_pend > 0 && !t) m_pend--;
    end else if (t) begin
`ifdef PULSE_QUEUE_EN
      if (m_pend == PMAX) m_drop = 1'b1;
      else m_pend++;
`else
      m_drop = 1'b1;
`endif
    end
  endtask

  task automatic step(input logic t);
    @(negedge clk);
    chk("pulse_out", 32'(pulse_out), 32'(cyc >= m_start && cyc < m_start + H));
    chk("busy", 32'(busy), 32'(cyc >= m_start && cyc < m_start + H + L));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
    if (cyc < 128) begin
      obs_p[cyc] = pulse_out;
      obs_b[cyc] = busy;
      obs_d[cyc] = drop_pulse;
      obs_q[cyc] = int'(pending);
    end
    trig_in = t;
    model(t);
    cyc++;
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) step(1'b0);
  endtask

  task automatic restart();
    trig_in = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 128; i++) begin
      obs_p[i] = 1'bx; obs_b[i] = 1'bx; obs_d[i] = 1'bx; obs_q[i] = -1;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_start = -100; m_pend = 0; m_drop = 1'b0; cyc = 0;
  endtask

  task automatic win(input string tag, input int lo, input int hi, input logic v);
    for (int c = lo; c <= hi; c++) chk($sformatf("%s[%0d]", tag, c), 32'(obs_p[c]), 32'(v));
  endtask

  initial begin
    // single pulse and immediate re-trigger after the final gap cycle
    restart();
    idle_to(10); step(1'b1); idle_to(18); step(1'b1); idle_to(30);
    win("single_hi", 11, 14, 1'b1); win("single_gap", 15, 17, 1'b0); win("retrig_hi", 19, 22, 1'b1);
    chk("single_busy11", 32'(obs_b[11]), 32'd1); chk("single_busy17", 32'(obs_b[17]), 32'd1);
    chk("single_idle18", 32'(obs_b[18]), 32'd0); chk("single_busy10", 32'(obs_b[10]), 32'd0);
    // asynchronous reset in the middle of a pulse
    restart();
    idle_to(10); step(1'b1); step(1'b0);
    @(negedge clk); #2 reset_n = 1'b0; #1;
    chk("rst_pulse", 32'(pulse_out), 32'd0); chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0); chk("rst_drop", 32'(drop_pulse), 32'd0);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    m_start = -100; m_pend = 0; m_drop = 1'b0; cyc = 15;
    idle_to(20); step(1'b1); idle_to(30);
    win("rst_retrig", 21, 24, 1'b1); win("rst_after", 25, 29, 1'b0);
    // trigger on the last gap cycle
    restart();
    idle_to(10); step(1'b1); idle_to(17); step(1'b1); idle_to(30);
    win("coin_hi1", 11, 14, 1'b1); win("coin_gap", 15, 17, 1'b0); win("coin_hi2", 18, 21, 1'b1);
    chk("coin_busy18", 32'(obs_b[18]), 32'd1); chk("coin_drop18", 32'(obs_d[18]), 32'd0);
    for (int c = 15; c <= 24; c++) chk($sformatf("coin_pend[%0d]", c), 32'(obs_q[c]), 32'd0);
`ifdef PULSE_QUEUE_EN
    // queued replay
    restart();
    idle_to(10); step(1'b1); step(1'b0); step(1'b1); step(1'b1); idle_to(32);
    win("q_hi1", 11, 14, 1'b1); win("q_gap1", 15, 17, 1'b0); win("q_hi2", 18, 21, 1'b1);
    win("q_gap2", 22, 24, 1'b0); win("q_hi3", 25, 28, 1'b1); win("q_end", 29, 31, 1'b0);
    chk("q_pend13", 32'(obs_q[13]), 32'd1); chk("q_pend14", 32'(obs_q[14]), 32'd2);
    // saturation
    restart();
    idle_to(10); repeat (6) step(1'b1); idle_to(50);
    chk("sat_pend14", 32'(obs_q[14]), 32'd3); chk("sat_pend16", 32'(obs_q[16]), 32'd3);
    chk("sat_drop14", 32'(obs_d[14]), 32'd0); chk("sat_drop15", 32'(obs_d[15]), 32'd1);
    chk("sat_drop16", 32'(obs_d[16]), 32'd1); chk("sat_drop17", 32'(obs_d[17]), 32'd0);
    begin
      int rises = 0;
      for (int c = 1; c < 50; c++) if (obs_p[c] === 1'b1 && obs_p[c-1] === 1'b0) rises++;
      chk("sat_pulse_count", 32'(rises), 32'd4);
    end
`else
    // requests while busy are dropped
    restart();
    idle_to(10); step(1'b1); step(1'b0); step(1'b1); idle_to(25);
    win("drop_hi", 11, 14, 1'b1); win("drop_lo", 15, 24, 1'b0);
    chk("drop12", 32'(obs_d[12]), 32'd0); chk("drop13", 32'(obs_d[13]), 32'd1);
    chk("drop14", 32'(obs_d[14]), 32'd0);
    for (int c = 11; c <= 20; c++) chk($sformatf("drop_pend[%0d]", c), 32'(obs_q[c]), 32'd0);
`endif
    // random traffic at light and heavy trigger density
    restart();
    repeat (800) step(logic'($urandom_range(0, 99) < 30));
    repeat (800) step(logic'($urandom_range(0, 99) < 75));
    repeat (200) step(logic'($urandom_range(0, 99) < 5));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_stretch_driver.md
# pulse_stretch_driver

Output-side counterpart to the team's input debouncer: the debouncer turns a bouncy external level into a clean internal signal, and this block turns fast internal one-cycle trigger events into a clean external pulse train. Each output pulse has a guaranteed minimum high time and minimum low gap, suitable for LEDs, relays, buzzers or slow off-chip logic. It sits between core logic and an output pad.

## Interface
- `HIGH_CYCLES`, default 1000: exact high time of each output pulse, in clk cycles (≥1).
- `LOW_CYCLES`, default 1000: exact minimum low gap after each pulse, in clk cycles (≥1).
- `CNT_WIDTH`, default 20: timer width; must hold max(HIGH_CYCLES, LOW_CYCLES)−1.
- `QDEPTH_W`, default 4: pending-request counter width; max pending = 2^QDEPTH_W − 1.
- `clk`, input, 1: single clock; all logic on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `trig_in`, input, 1: request for one output pulse; each high cycle is one request.
- `pulse_out`, output, 1: stretched pulse to the pad; registered.
- `busy`, output, 1: high while in HIGH or GAP state; registered.
- `pending`, output, QDEPTH_W: count of queued requests not yet started.
- `drop_pulse`, output, 1: one-cycle flag, high when a request was discarded.

## Operation
- Reset (async assert): state = IDLE, timer = 0, `pulse_out` = 0, `busy` = 0, `pending` = 0, `drop_pulse` = 0. Deassertion is synchronous to clk.
- States: IDLE, HIGH, GAP.
- **IDLE:** `trig_in` = 1 → HIGH, timer loaded with HIGH_CYCLES−1. `pending` is 0 in IDLE.
- **HIGH:** `pulse_out` = 1. Timer decrements each cycle. At timer == 0 → GAP, timer loaded with LOW_CYCLES−1.
- **GAP:** `pulse_out` = 0. Timer decrements each cycle. At timer == 0:
  - if `pending` > 0 or `trig_in` = 1 → HIGH, reload timer with HIGH_CYCLES−1.
  - `pending` decrements only if it was > 0; otherwise the same-cycle `trig_in` is consumed directly.
  - otherwise → IDLE.
- **Requests while busy:** `trig_in` in HIGH or GAP (other than the consuming cycle above) is a new request. It is queued or dropped per Configuration.
- **Simultaneous queue increment and decrement:** at the GAP→HIGH cycle with `pending` > 0 and `trig_in` = 1, `pending` is unchanged.
- **Saturation:** a request arriving with `pending` at max is dropped. `pending` holds and `drop_pulse` = 1 on the next cycle.
- **Arithmetic:** the timer never wraps; it is always reloaded at 0. `pending` never wraps in either direction.
- **Reset mid-pulse:** `pulse_out` falls immediately (asynchronously). The queue is cleared and no gap is enforced after reset.

## Timing
- Latency: `trig_in` high in cycle N while IDLE → `pulse_out` high in cycles N+1 … N+HIGH_CYCLES, low for at least LOW_CYCLES cycles after that.
- `busy` equals (state ≠ IDLE). It is high from N+1 through the last GAP cycle.
- Back-to-back queued pulses have a period of exactly HIGH_CYCLES + LOW_CYCLES.
- `drop_pulse` asserts the cycle after the dropped `trig_in` and lasts 1 cycle per dropped request.
- A new IDLE trigger is accepted in the first cycle after the final GAP cycle.

## Configuration
- `PULSE_QUEUE_EN` defined: requests arriving while busy are counted in `pending` and replayed in order, with saturation as described in Operation.
- `PULSE_QUEUE_EN` not defined:
  - every request arriving while busy is dropped and flags `drop_pulse`;
  - `pending` is tied to 0;
  - the GAP→HIGH transition occurs only on a same-cycle `trig_in` at timer == 0.

## Test plan
All scenarios use HIGH_CYCLES=4, LOW_CYCLES=3, CNT_WIDTH=8, QDEPTH_W=2.
- **Reset:** assert `reset_n`=0 mid-HIGH at cycle 12 → `pulse_out`, `busy`, `pending`, `drop_pulse` all read 0 immediately; after release, `trig_in` at 20 → pulse in cycles 21–24.
- **Single pulse:** `trig_in` at cycle 10 → `pulse_out` = 1 in cycles 11–14, 0 in 15–17; `busy` = 1 in 11–17; IDLE at 18; a trigger at 18 gives a pulse in 19–22.
- **Queue (macro on):** triggers at cycles 10, 12, 13 → pulses in 11–14, 18–21, 25–28; `pending` reads 1 at cycle 13 and 2 at cycle 14.
- **Saturation (macro on):** trigger at 10, then triggers at 11–15 → `pending` saturates at 3; `drop_pulse` = 1 in cycles 15 and 16; exactly 4 pulses total.
- **Drop (macro off):** triggers at 10 and 12 → one pulse in 11–14; `drop_pulse` = 1 at cycle 13; `pending` stays 0.
- **GAP-end coincidence:** trigger at 10, then `trig_in` at cycle 17 (last GAP cycle) → next pulse in 18–21 with `pending` unchanged at 0; check with the macro both on and off.
